// File: rtl/homing_pkg.sv
// Shared types for the axis homing controller: FSM state encoding and error codes.
package homing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FAST_SEEK = 3'd1,
    ST_BACKOFF   = 3'd2,
    ST_SLOW_SEEK = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FAST_TO = 2'd1;
  localparam logic [1:0] ERR_SLOW_TO = 2'd2;
  localparam logic [1:0] ERR_STUCK   = 2'd3;

endpackage

// File: rtl/step_pulse_gen.sv
// Step period counter: the pulse occupies the last STEP_PULSE cycles of each period,
// so direction has the whole head of the period to settle before the edge.
module step_pulse_gen #(
  parameter int unsigned STEP_PULSE = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] period,
  input  logic        enable,
  input  logic        clear,
  output logic        step,
  output logic        period_done
);

  logic [31:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= period_done ? '0 : cnt + 32'd1;
    end
  end

  assign step        = enable && (cnt >= period - 32'(STEP_PULSE));
  assign period_done = enable && (cnt == period - 32'd1);

endmodule

// File: rtl/axis_homing_ctrl.sv
// One-axis homing sequencer: fast seek to the endstop, fixed back-off, slow re-approach.
// Step and dir are decoded from registered state so reset or abort drops step at once.
module axis_homing_ctrl
  import homing_pkg::*;
#(
  parameter int unsigned FAST_PERIOD   = 2000,
  parameter int unsigned SLOW_PERIOD   = 20000,
  parameter int unsigned STEP_PULSE    = 50,
  parameter int unsigned BACKOFF_STEPS = 200,
  parameter int unsigned MAX_STEPS     = 100000,
  parameter logic        HOME_DIR      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        endstop,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] seek_steps
);

  state_e      state, state_n;
  logic [31:0] step_cnt, step_inc, period, seek_val;
  logic        period_done, entering, hit_pend;
  logic        seek_hit, at_limit, start_acc, seek_load, err_set;
  logic [1:0]  err_val;

  assign busy     = (state == ST_FAST_SEEK) || (state == ST_BACKOFF) || (state == ST_SLOW_SEEK);
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERROR);
  assign dir      = (state == ST_BACKOFF) ? ~HOME_DIR : HOME_DIR;
  assign period   = (state == ST_FAST_SEEK) ? 32'(FAST_PERIOD) : 32'(SLOW_PERIOD);
  assign step_inc = step_cnt + 32'd1;
  assign entering = (state_n != state);

  // Contact before the pulse starts leaves at once; contact during a pulse (seen now or
  // remembered in hit_pend) lets that pulse finish and leaves at the period end.
  assign seek_hit = (endstop && !step) || (period_done && (endstop || hit_pend));
  assign at_limit = period_done && (step_inc == 32'(MAX_STEPS));

  step_pulse_gen #(.STEP_PULSE(STEP_PULSE)) u_pulse (
    .clk         (clk),
    .rst         (rst),
    .period      (period),
    .enable      (busy),
    .clear       (entering),
    .step        (step),
    .period_done (period_done)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    seek_load = 1'b0;
    seek_val  = step_inc;
    err_set   = 1'b0;
    err_val   = ERR_NONE;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start && !abort) begin
          start_acc = 1'b1;
          if (endstop) begin
            state_n   = ST_BACKOFF;
            seek_load = 1'b1;
            seek_val  = '0;
          end else begin
            state_n = ST_FAST_SEEK;
          end
        end
      end
      ST_FAST_SEEK: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (seek_hit) begin
          state_n   = ST_BACKOFF;
          seek_load = 1'b1;
          seek_val  = period_done ? step_inc : step_cnt;
        end else if (at_limit) begin
          state_n   = ST_ERROR;
          seek_load = 1'b1;
          err_set   = 1'b1;
          err_val   = ERR_FAST_TO;
        end
      end
      ST_BACKOFF: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (period_done && (step_inc == 32'(BACKOFF_STEPS))) begin
          if (endstop) begin
            state_n = ST_ERROR;
            err_set = 1'b1;
            err_val = ERR_STUCK;
          end else begin
            state_n = ST_SLOW_SEEK;
          end
        end
      end
      ST_SLOW_SEEK: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (seek_hit) begin
          state_n = ST_DONE;
        end else if (at_limit) begin
          state_n = ST_ERROR;
          err_set = 1'b1;
          err_val = ERR_SLOW_TO;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      step_cnt   <= '0;
      hit_pend   <= 1'b0;
      err_code   <= ERR_NONE;
      seek_steps <= '0;
    end else begin
      state <= state_n;
      if (entering) begin
        step_cnt <= '0;
        hit_pend <= 1'b0;
      end else begin
        if (period_done) step_cnt <= step_inc;
        if (endstop && step && (state != ST_BACKOFF)) hit_pend <= 1'b1;
      end
      if (start_acc) err_code <= ERR_NONE;
      else if (err_set) err_code <= err_val;
      if (seek_load) seek_steps <= seek_val;
    end
  end

endmodule

// File: tb/tb_axis_homing_ctrl.sv
// Scoreboard bench: an endstop schedule is drawn per run, a phase-level model predicts every
// step pulse (rise cycle, width, dir) and the final outcome; a negedge monitor compares.
module tb_axis_homing_ctrl;

  localparam int FP  = 8;
  localparam int SP  = 16;
  localparam int PW  = 2;
  localparam int BO  = 4;
  localparam int MS  = 20;
  localparam int NES = 1024;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, endstop = 1'b0;
  logic        step, dir, busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] seek_steps;

  axis_homing_ctrl #(
    .FAST_PERIOD(FP), .SLOW_PERIOD(SP), .STEP_PULSE(PW),
    .BACKOFF_STEPS(BO), .MAX_STEPS(MS), .HOME_DIR(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .endstop(endstop),
    .step(step), .dir(dir), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .seek_steps(seek_steps)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // endstop schedule: level per cycle after the start cycle, es_pre for the start cycle itself
  bit es_pre;
  bit es_tab[NES];

  function automatic bit es(int c);
    if (c < 0) return es_pre;
    if (c >= NES) return es_tab[NES-1];
    return es_tab[c];
  endfunction

  function automatic int first_hit(int from, int to);
    for (int c = from; c <= to; c++) if (es(c)) return c;
    return -1;
  endfunction

  task automatic make_sched(input bit pre, input int h1, input int d, input int g);
    es_pre = pre;
    for (int c = 0; c < NES; c++) es_tab[c] = ((c >= h1) && (c < h1 + d)) || (c >= h1 + d + g);
  endtask

  function automatic longint pk_pulse(int rise, int width, bit d);
    return longint'(rise) * 1000 + width * 10 + d;
  endfunction

  function automatic longint pk_res(int fin, int seek, bit dn, bit er, int code);
    return longint'(fin) * 1000000 + longint'(seek) * 1000 + dn * 100 + er * 10 + code;
  endfunction

  longint exp_pulse[$];
  longint exp_res[$];
  int     m_rise[$];
  bit     m_dir[$];
  int     model_seek = 0;

  // One seek of period p starting at cycle s; returns the cycle the next phase begins.
  task automatic seek_phase(input int s, input int p, input bit d,
                            output int nxt, output int steps, output bit hit);
    int h;
    h = first_hit(s, s + p * MS - 1);
    if (h < 0) begin
      steps = MS; hit = 1'b0; nxt = s + p * MS;
    end else begin
      hit = 1'b1;
      if ((h - s) % p < p - PW) begin
        steps = (h - s) / p; nxt = h + 1;
      end else begin
        steps = (h - s) / p + 1; nxt = s + p * steps;
      end
    end
    for (int i = 0; i < steps; i++) begin
      m_rise.push_back(s + p * i + p - PW);
      m_dir.push_back(d);
    end
  endtask

  task automatic predict(input int kill_at, input bit kill_rst);
    int b, fin, steps, seek_new, seek_at, code;
    bit hit, dn, er;
    m_rise.delete(); m_dir.delete();
    dn = 0; er = 0; code = 0; fin = 0; seek_at = 0; b = 0;
    if (es(-1)) begin
      seek_new = 0;
    end else begin
      seek_phase(0, FP, 1'b0, b, steps, hit);
      seek_new = steps; seek_at = b;
      if (!hit) begin fin = b; er = 1; code = 1; end
    end
    if (!er) begin
      for (int i = 0; i < BO; i++) begin
        m_rise.push_back(b + SP * i + SP - PW);
        m_dir.push_back(1'b1);
      end
      if (es(b + SP * BO - 1)) begin
        fin = b + SP * BO; er = 1; code = 3;
      end else begin
        seek_phase(b + SP * BO, SP, 1'b0, fin, steps, hit);
        if (hit) dn = 1;
        else begin er = 1; code = 2; end
      end
    end
    if (kill_at >= 0 && kill_at < fin) begin
      fin = kill_at + 1; dn = 0; er = 0; code = 0;
      if (kill_rst) seek_new = 0;
      else if (seek_at > kill_at) seek_new = model_seek;
    end
    foreach (m_rise[i])
      if (m_rise[i] < fin)
        exp_pulse.push_back(pk_pulse(m_rise[i], (fin - m_rise[i] < PW) ? fin - m_rise[i] : PW, m_dir[i]));
    exp_res.push_back(pk_res(fin, seek_new, dn, er, code));
    model_seek = seek_new;
  endtask

  // monitor
  int cyc = 0;
  int start_cyc = 0;
  int n_ends = 0;
  bit run_active = 1'b0;
  bit prev_step = 1'b0, prev_busy = 1'b0, cur_dir = 1'b0;
  int cur_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (run_active) begin
      if (step && !prev_step) begin
        cur_rise <= cyc - start_cyc;
        cur_dir  <= dir;
      end
      if (!step && prev_step) begin
        if (exp_pulse.size() == 0) check("extra_pulse", pk_pulse(cur_rise, cyc - start_cyc - cur_rise, cur_dir), -1);
        else check("pulse", pk_pulse(cur_rise, cyc - start_cyc - cur_rise, cur_dir), exp_pulse.pop_front());
      end
      if (!busy && prev_busy) begin
        if (exp_res.size() == 0) check("extra_result", pk_res(cyc - start_cyc, seek_steps, done, error, err_code), -1);
        else check("result", pk_res(cyc - start_cyc, seek_steps, done, error, err_code), exp_res.pop_front());
        n_ends <= n_ends + 1;
      end
    end
    prev_step <= step;
    prev_busy <= busy;
  end

  task automatic run(input int kill_at, input bit kill_rst, input bit extra);
    int c, ends0;
    predict(kill_at, kill_rst);
    @(negedge clk); #1;
    ends0 = n_ends;
    start_cyc = cyc + 1;
    endstop = es(-1);
    start = 1'b1;
    run_active = 1'b1;
    c = 0;
    while (n_ends == ends0 && c < 3000) begin
      @(negedge clk); #1;
      start   = extra && (c == 3);
      abort   = !kill_rst && (c == kill_at);
      endstop = es(c);
      if (kill_rst && c == kill_at) begin
        check("step_before_rst", step, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_step", step, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_flags", {done, error, err_code}, 0);
        check("rst_async_dir", dir, 0);
        check("rst_async_seek", seek_steps, 0);
      end
      c++;
    end
    start = 1'b0;
    abort = 1'b0;
    run_active = 1'b0;
    check("run_ended", n_ends - ends0, 1);
    check("pulses_left", exp_pulse.size(), 0);
    exp_pulse.delete();
    exp_res.delete();
    if (kill_rst) begin
      @(negedge clk);
      rst = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int h1, d, g, kill;
    bit pre, extra;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_step", step, 0);
    check("reset_dir", dir, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_err_code", err_code, 0);
    check("reset_seek", seek_steps, 0);
    rst = 1'b0;
    @(negedge clk);

    make_sched(1'b0, 40, 33, 80);      run(-1, 1'b0, 1'b0);  // nominal homing
    make_sched(1'b0, 100000, 0, 0);    run(-1, 1'b0, 1'b0);  // fast timeout
    make_sched(1'b1, 0, NES, 0);       run(-1, 1'b0, 1'b0);  // stuck endstop
    make_sched(1'b0, 100000, 0, 0);    run(23, 1'b0, 1'b0);  // abort at cnt 7
    make_sched(1'b0, 40, 33, 80);      run(-1, 1'b0, 1'b1);  // re-home, start while busy
    make_sched(1'b0, 19, 40, 60);      run(-1, 1'b0, 1'b0);  // contact before pulse
    make_sched(1'b0, 22, 40, 60);      run(-1, 1'b0, 1'b1);  // contact mid-pulse
    make_sched(1'b0, 40, 33, 80);      run(119, 1'b1, 1'b0); // reset during slow pulse

    repeat (30) begin
      pre   = ($urandom_range(5, 0) == 0);
      h1    = $urandom_range(169, 0);
      d     = 1 + $urandom_range(79, 0);
      g     = $urandom_range(359, 0);
      kill  = ($urandom_range(3, 0) == 0) ? 5 + $urandom_range(399, 0) : -1;
      extra = $urandom_range(1, 0);
      make_sched(pre, h1, d, g);
      run(kill, 1'b0, extra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_homing_ctrl.md
Name: axis_homing_ctrl

Overview:
- Sequences one axis homing cycle: fast seek toward the endstop, fixed back-off, slow re-approach, then reports completion.
- Drives the axis stepper step/dir lines.
- Consumes the debounced endstop level produced by the endstop filter.
- Sits between the host command decoder (start/abort) and the stepper driver outputs; one instance per axis.

Parameters:
- FAST_PERIOD, 2000, clk cycles per step during the fast seek (must be > STEP_PULSE).
- SLOW_PERIOD, 20000, clk cycles per step during the slow seek and back-off (must be > STEP_PULSE).
- STEP_PULSE, 50, step high width in clk cycles (>= 1).
- BACKOFF_STEPS, 200, steps moved away from the endstop after first contact.
- MAX_STEPS, 100000, seek step limit (applied separately to each seek) before a timeout error.
- HOME_DIR, 0, dir level that moves toward the endstop.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin homing
- abort  in  1  level; cancels an active homing cycle
- endstop  in  1  filtered endstop level, 1 = triggered
- step  out  1  stepper step pulse
- dir  out  1  stepper direction
- busy  out  1  high while not IDLE/DONE/ERROR
- done  out  1  sticky success flag
- error  out  1  sticky failure flag
- err_code  out  2  0 none, 1 fast-seek timeout, 2 slow-seek timeout, 3 endstop stuck after back-off
- seek_steps  out  32  steps taken in the last fast seek

Behaviour:
- Reset (async, rst=1): state IDLE; step=0, dir=HOME_DIR, busy=0, done=0, error=0, err_code=0, seek_steps=0; all counters 0. Reset mid-motion drops step immediately.
- States: IDLE, FAST_SEEK, BACKOFF, SLOW_SEEK, DONE, ERROR.
- Motion-state timing (FAST_SEEK, BACKOFF, SLOW_SEEK):
  - Period counter cnt runs 0..P-1, with P = FAST_PERIOD or SLOW_PERIOD.
  - cnt and the step counter clear on every state entry.
  - step = 1 exactly when cnt >= P-STEP_PULSE, i.e. the pulse occupies the tail of each period.
  - dir is therefore stable P-STEP_PULSE cycles before the first pulse.
  - The step counter increments at cnt == P-1.
- IDLE/DONE/ERROR:
  - start=1 clears done, error and err_code, then enters the first state next cycle.
  - The first state is FAST_SEEK, or BACKOFF directly if endstop=1 at start; in the BACKOFF case seek_steps=0.
  - start while busy is ignored.
- FAST_SEEK: dir=HOME_DIR, P=FAST_PERIOD.
  - If endstop=1 while cnt < P-STEP_PULSE: go to BACKOFF next cycle; no further pulse issued.
  - If endstop rises during a pulse: the pulse completes, then go to BACKOFF after cnt == P-1.
  - seek_steps is latched with the step count on exit.
  - Step count reaching MAX_STEPS without endstop: go to ERROR with err_code=1.
- BACKOFF: dir=~HOME_DIR, P=SLOW_PERIOD.
  - After BACKOFF_STEPS completed periods, sample endstop: 0 -> SLOW_SEEK; 1 -> ERROR with err_code=3.
- SLOW_SEEK: dir=HOME_DIR, P=SLOW_PERIOD.
  - Same endstop rule as FAST_SEEK, with exit to DONE.
  - MAX_STEPS reached without endstop -> ERROR with err_code=2.
- DONE: done=1, busy=0. ERROR: error=1, busy=0. Both hold until the next start.
- abort=1 in any motion state:
  - Next cycle: state IDLE, step=0 (a pulse may be truncated), busy=0.
  - done/error are not set; seek_steps is unchanged.
  - abort has priority over endstop and counter events in the same cycle.
- Simultaneous start and abort in IDLE: abort wins, stay in IDLE.
- Counters are 32-bit unsigned; no wrap is possible because MAX_STEPS < 2^32.
- busy rises the cycle after start is accepted.
- Latency start -> first step rising edge = 1 + FAST_PERIOD-STEP_PULSE cycles.

Decomposition:
- Shared package homing_pkg holds:
  - the state enum typedef (6 states, 3 bits);
  - err_code localparams ERR_NONE/ERR_FAST_TO/ERR_SLOW_TO/ERR_STUCK.
- One sub-module, step_pulse_gen:
  - inputs: period, enable, clear;
  - outputs: step, period_done;
  - holds cnt and the step comparator.
- The controller FSM and step counter live in axis_homing_ctrl.

Test Plan:
(Bench parameters: FAST_PERIOD=8, SLOW_PERIOD=16, STEP_PULSE=2, BACKOFF_STEPS=4, MAX_STEPS=20, HOME_DIR=0.)
- Nominal homing:
  - Stimulus: start; endstop raised after 5 fast steps; endstop drops after 2 back-off steps; endstop raised after 3 slow steps.
  - Required response:
    - first step rises 7 cycles after start;
    - seek_steps=5;
    - dir=1 during back-off with 4 back-off pulses;
    - 3 slow pulses, then done=1, busy=0, err_code=0.
- Fast timeout: start with endstop held 0 -> exactly 20 pulses of period 8, then error=1, err_code=1, step=0.
- Stuck endstop: endstop=1 throughout, then start -> FAST_SEEK skipped, 4 pulses with dir=1, then error=1, err_code=3, seek_steps=0.
- Abort mid-pulse: abort asserted at cnt=7 of a fast step -> step=0 and busy=0 next cycle; done=0, error=0. A subsequent start re-homes normally.
- Async reset during SLOW_SEEK with step=1 -> step=0 with no clock edge needed; all outputs hold reset values.
- Endstop edge rule:
  - endstop rises at cnt=3 -> no further pulse;
  - endstop rises at cnt=6 (mid-pulse) -> pulse still 2 cycles wide, transition at cnt=7;
  - start pulsed while busy -> no effect.
